// File: rtl/adder_measure_pkg.sv
// adder_measure_pkg: state encoding and default timing constants shared by the
// adder measurement sequencer and its ring-counter sampler.
package adder_measure_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        ARM,
        RUN,
        SETTLE,
        SAMPLE,
        RESULT
    } measState_t;

    localparam int DEFAULT_SETTLE_CYCLES = 4;
    localparam int DEFAULT_MAX_RETRIES   = 3;

endpackage

// File: rtl/adder_measure_sequencer_stable_sampler.sv
// stable_sampler: registers an asynchronous counter bus on every clock and
// compares two consecutive captures. A match means the bus held still long
// enough to trust the value; the owner counts failed compares through the
// retry counter kept here.
module stable_sampler
    import adder_measure_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RETRY_BITS = $clog2(DEFAULT_MAX_RETRIES + 2)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_b,
    input  logic [WIDTH-1:0]      i_bus,
    input  logic                  i_clearRetries,
    input  logic                  i_countRetry,
    output logic                  o_match,
    output logic [WIDTH-1:0]      o_sample,
    output logic [RETRY_BITS-1:0] o_retries
);

    logic [WIDTH-1:0]      r_sampleNew;
    logic [WIDTH-1:0]      r_sampleOld;
    logic [RETRY_BITS-1:0] r_retries;

    // Capture the bus each cycle and keep the previous capture beside it
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_sampleNew <= '0;
            r_sampleOld <= '0;
        end else begin
            r_sampleNew <= i_bus;
            r_sampleOld <= r_sampleNew;
        end
    end

    // Saturating count of failed compares for the readout in progress
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_retries <= '0;
        end else if (i_clearRetries) begin
            r_retries <= '0;
        end else if (i_countRetry && (r_retries != '1)) begin
            r_retries <= r_retries + RETRY_BITS'(1);
        end
    end

    assign o_match   = (r_sampleNew == r_sampleOld);
    assign o_sample  = r_sampleNew;
    assign o_retries = r_retries;

endmodule

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: runs one measurement of the instrumented adder --
// clear, load, enable, wait for done, settle, then capture the ring counter
// with a double-sample check. Every output is registered from the next state.
// Optional feature macro ADDER_MEASURE_ACCUM_EN: when defined, the run is
// repeated repeats+1 times and the captures are summed; when undefined, the
// repeat count is ignored and the single capture is reported.
module adder_measure_sequencer
    import adder_measure_pkg::*;
#(
    parameter int COUNT_BITS    = 32,
    parameter int REP_BITS      = 4,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEFAULT_MAX_RETRIES
) (
    input  logic                           i_clk,
    input  logic                           i_reset_b,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [COUNT_BITS-1:0]          i_integration_time,
    input  logic [REP_BITS-1:0]            i_repeats,
    output logic                           o_dut_reset,
    output logic                           o_dut_counter_load,
    output logic                           o_dut_counter_enable,
    output logic [COUNT_BITS-1:0]          o_dut_integration_time,
    input  logic                           i_dut_done,
    input  logic [COUNT_BITS-1:0]          i_dut_ring_count,
    output logic                           o_busy,
    output logic                           o_result_valid,
    input  logic                           i_result_ready,
    output logic [COUNT_BITS+REP_BITS-1:0] o_result_count,
    output logic                           o_error
);

    localparam int ACC_BITS    = COUNT_BITS + REP_BITS;
    localparam int SETTLE_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RETRY_BITS  = $clog2(MAX_RETRIES + 2);

    measState_t            r_state;
    measState_t            w_nextState;
    logic [SETTLE_BITS-1:0] r_settleCount;
    logic                  r_samplePhase;
    logic [REP_BITS-1:0]   r_runIndex;
    logic [REP_BITS-1:0]   r_repeats;
    logic [REP_BITS-1:0]   w_repeatsLatch;
    logic                  w_startAccept;
    logic                  w_lastRun;
    logic                  w_capture;
    logic                  w_retry;
    logic                  w_giveUp;
    logic                  w_match;
    logic [COUNT_BITS-1:0] w_sample;
    logic [RETRY_BITS-1:0] w_retries;
    logic [ACC_BITS-1:0]   w_accumNext;

    stable_sampler #(
        .WIDTH      (COUNT_BITS),
        .RETRY_BITS (RETRY_BITS)
    ) u_sampler (
        .i_clk          (i_clk),
        .i_reset_b      (i_reset_b),
        .i_bus          (i_dut_ring_count),
        .i_clearRetries (r_state != SAMPLE),
        .i_countRetry   (w_retry),
        .o_match        (w_match),
        .o_sample       (w_sample),
        .o_retries      (w_retries)
    );

`ifdef ADDER_MEASURE_ACCUM_EN
    logic [ACC_BITS-1:0] r_accum;

    assign w_accumNext    = r_accum + ACC_BITS'(w_sample);
    assign w_repeatsLatch = i_repeats;

    // Running sum of captures, restarted by each accepted start
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_accum <= '0;
        end else if (w_startAccept) begin
            r_accum <= '0;
        end else if (w_capture) begin
            r_accum <= w_accumNext;
        end
    end
`else
    logic w_unusedRepeats;

    assign w_unusedRepeats = ^i_repeats;
    assign w_accumNext     = ACC_BITS'(w_sample);
    assign w_repeatsLatch  = '0;
`endif

    assign w_startAccept = (r_state == IDLE) && i_start && !i_abort;
    assign w_lastRun     = (r_runIndex == r_repeats);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and capture decisions; abort overrides everything
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_retry     = 1'b0;
        w_giveUp    = 1'b0;
        case (r_state)
            IDLE:   if (i_start) w_nextState = CLEAR;
            CLEAR:  w_nextState = LOAD;
            LOAD:   w_nextState = ARM;
            ARM:    w_nextState = RUN;
            RUN:    if (i_dut_done) w_nextState = SETTLE;
            SETTLE: if (r_settleCount == SETTLE_BITS'(SETTLE_CYCLES - 1)) w_nextState = SAMPLE;
            SAMPLE: begin
                if (r_samplePhase) begin
                    if (w_match) begin
                        w_capture = 1'b1;
                    end else if (w_retries == RETRY_BITS'(MAX_RETRIES)) begin
                        w_capture = 1'b1;
                        w_giveUp  = 1'b1;
                    end else begin
                        w_retry = 1'b1;
                    end
                    if (w_capture) begin
                        w_nextState = w_lastRun ? RESULT : CLEAR;
                    end
                end
            end
            RESULT: if (i_result_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (i_abort) begin
            w_nextState = IDLE;
            w_capture   = 1'b0;
            w_retry     = 1'b0;
            w_giveUp    = 1'b0;
        end
    end

    // Settle timer and sample-phase toggle, both restart whenever their state is left
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_settleCount <= '0;
            r_samplePhase <= 1'b0;
        end else begin
            r_settleCount <= ((r_state == SETTLE) && (w_nextState == SETTLE))
                             ? r_settleCount + SETTLE_BITS'(1) : '0;
            r_samplePhase <= ((r_state == SAMPLE) && (w_nextState == SAMPLE))
                             ? ~r_samplePhase : 1'b0;
        end
    end

    // Run bookkeeping, latched configuration and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_runIndex             <= '0;
            r_repeats              <= '0;
            o_dut_reset            <= 1'b1;
            o_dut_counter_load     <= 1'b0;
            o_dut_counter_enable   <= 1'b0;
            o_dut_integration_time <= '0;
            o_busy                 <= 1'b0;
            o_result_valid         <= 1'b0;
            o_result_count         <= '0;
            o_error                <= 1'b0;
        end else begin
            o_dut_reset          <= (w_nextState == CLEAR);
            o_dut_counter_load   <= (w_nextState == LOAD);
            o_dut_counter_enable <= (w_nextState == ARM) || (w_nextState == RUN) ||
                                    (w_nextState == SETTLE) || (w_nextState == SAMPLE);
            o_busy               <= (w_nextState != IDLE);
            o_result_valid       <= (w_nextState == RESULT);
            if (w_startAccept) begin
                o_dut_integration_time <= i_integration_time;
                r_repeats              <= w_repeatsLatch;
                r_runIndex             <= '0;
                o_error                <= 1'b0;
            end else if (w_capture && !w_lastRun) begin
                r_runIndex <= r_runIndex + REP_BITS'(1);
            end
            if (w_giveUp) begin
                o_error <= 1'b1;
            end
            if (w_capture && w_lastRun) begin
                o_result_count <= w_accumNext;
            end
        end
    end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// tb_adder_measure_sequencer: drives the sequencer against a behavioural
// instrumented-adder model (down-counter plus a ring counter advancing once
// per two enabled clocks) and scores each delivered result against a queue
// of expected results pushed when the run is started.
module tb_adder_measure_sequencer;

    typedef struct {
        logic [35:0] count;
        logic [35:0] mask;
        logic        err;
    } expEntry_t;

    logic        clk             = 1'b0;
    logic        resetB          = 1'b0;
    logic        start           = 1'b0;
    logic        abort           = 1'b0;
    logic [31:0] integrationTime = 32'd0;
    logic [3:0]  repeats         = 4'd0;
    logic        resultReady     = 1'b1;
    logic        dutReset;
    logic        dutLoad;
    logic        dutEnable;
    logic [31:0] dutIntegrationTime;
    logic        dutDone;
    logic [31:0] dutRingCount;
    logic        busy;
    logic        resultValid;
    logic [35:0] resultCount;
    logic        error;

    logic [31:0] modelCnt   = 32'd0;
    logic [31:0] modelRing  = 32'd0;
    logic        modelHalf  = 1'b0;
    logic        toggleBit  = 1'b0;
    logic        toggleMode = 1'b0;

    int          checks   = 0;
    int          failures = 0;
    expEntry_t   expQ[$];
    expEntry_t   monExp;

    adder_measure_sequencer #(
        .COUNT_BITS    (32),
        .REP_BITS      (4),
        .SETTLE_CYCLES (4),
        .MAX_RETRIES   (3)
    ) dut (
        .i_clk                  (clk),
        .i_reset_b              (resetB),
        .i_start                (start),
        .i_abort                (abort),
        .i_integration_time     (integrationTime),
        .i_repeats              (repeats),
        .o_dut_reset            (dutReset),
        .o_dut_counter_load     (dutLoad),
        .o_dut_counter_enable   (dutEnable),
        .o_dut_integration_time (dutIntegrationTime),
        .i_dut_done             (dutDone),
        .i_dut_ring_count       (dutRingCount),
        .o_busy                 (busy),
        .o_result_valid         (resultValid),
        .i_result_ready         (resultReady),
        .o_result_count         (resultCount),
        .o_error                (error)
    );

    always #5 clk = ~clk;

    // Behavioural adder: loaded down-counter, ring counter gated by its zero detect
    always @(posedge clk) begin
        toggleBit <= ~toggleBit;
        if (dutReset === 1'b1) begin
            modelCnt  <= 32'd0;
            modelRing <= 32'd0;
            modelHalf <= 1'b0;
        end else if (dutLoad === 1'b1) begin
            modelCnt <= dutIntegrationTime;
        end else if (dutEnable === 1'b1 && modelCnt != 32'd0) begin
            modelCnt  <= modelCnt - 32'd1;
            modelHalf <= ~modelHalf;
            if (modelHalf) modelRing <= modelRing + 32'd1;
        end
    end

    assign dutDone      = (modelCnt == 32'd0);
    assign dutRingCount = toggleMode ? (modelRing ^ {31'd0, toggleBit}) : modelRing;

    // Scoreboard: every accepted result is popped and compared
    always @(negedge clk) begin
        if (resetB === 1'b1 && resultValid === 1'b1 && resultReady === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_result: got count=%0d, expected no result", resultCount);
            end else begin
                monExp = expQ.pop_front();
                if ((resultCount & monExp.mask) !== (monExp.count & monExp.mask)) begin
                    failures++;
                    $display("[TB] FAIL result_count: got %0d, expected %0d", resultCount, monExp.count);
                end
                checks++;
                if (error !== monExp.err) begin
                    failures++;
                    $display("[TB] FAIL result_error: got %b, expected %b", error, monExp.err);
                end
            end
        end
    end

    task automatic pushExpected(input logic [35:0] cnt, input logic [35:0] msk, input logic err);
        expEntry_t e;
        e.count = cnt;
        e.mask  = msk;
        e.err   = err;
        expQ.push_back(e);
    endtask

    // Pulses start for one cycle (cycle 0); returns just after the start of cycle 1
    task automatic applyStimulus(input logic [31:0] itime, input logic [3:0] reps);
        @(posedge clk); #1;
        integrationTime = itime;
        repeats         = reps;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetB = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dutReset !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_dut_reset: got %b, expected 1", dutReset);
        end
        checks++;
        if ({dutLoad, dutEnable, busy, resultValid, error} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000", {dutLoad, dutEnable, busy, resultValid, error});
        end
        checks++;
        if (resultCount !== 36'd0 || dutIntegrationTime !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got count=%0d itime=%0d, expected 0 and 0", resultCount, dutIntegrationTime);
        end
        @(posedge clk); #1;
        resetB = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dutReset !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got dut_reset=%b busy=%b, expected 0 0", dutReset, busy);
        end
    endtask

    task automatic test_single();
        int k, doneAt, validAt;
        pushExpected(36'd50, {36{1'b1}}, 1'b0);
        applyStimulus(32'd100, 4'd0);
        k = 1; doneAt = -1; validAt = -1;
        while (k < 400 && validAt < 0) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (dutReset !== 1'b1 || busy !== 1'b1 || dutIntegrationTime !== 32'd100) begin
                    failures++;
                    $display("[TB] FAIL clear_cycle: got reset=%b busy=%b itime=%0d, expected 1 1 100", dutReset, busy, dutIntegrationTime);
                end
            end
            if (k == 2) begin
                checks++;
                if (dutLoad !== 1'b1 || dutReset !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL load_cycle: got load=%b reset=%b, expected 1 0", dutLoad, dutReset);
                end
            end
            if (k == 3) begin
                checks++;
                if (dutEnable !== 1'b1 || dutLoad !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL arm_cycle: got enable=%b load=%b, expected 1 0", dutEnable, dutLoad);
                end
            end
            if (k >= 4 && doneAt < 0 && dutDone === 1'b1) doneAt = k;
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (doneAt != 103) begin
            failures++;
            $display("[TB] FAIL done_cycle: got %0d, expected 103", doneAt);
        end
        checks++;
        if (validAt != 110) begin
            failures++;
            $display("[TB] FAIL valid_latency: got cycle %0d, expected %0d (done+7)", validAt, doneAt + 7);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resultValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_result: got busy=%b valid=%b, expected 0 0", busy, resultValid);
        end
    endtask

    task automatic test_zero_time();
        int k, validAt;
        pushExpected(36'd0, {36{1'b1}}, 1'b0);
        applyStimulus(32'd0, 4'd0);
        k = 1; validAt = -1;
        while (k < 100 && validAt < 0) begin
            @(negedge clk);
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (validAt != 11) begin
            failures++;
            $display("[TB] FAIL zero_time_latency: got cycle %0d, expected 11", validAt);
        end
    endtask

    task automatic test_repeats();
        int   k, validAt, pulses, expPulses, expValidAt;
        logic prevReset;
`ifdef ADDER_MEASURE_ACCUM_EN
        pushExpected(36'd200, {36{1'b1}}, 1'b0);
        expPulses  = 4;
        expValidAt = 437;
`else
        pushExpected(36'd50, {36{1'b1}}, 1'b0);
        expPulses  = 1;
        expValidAt = 110;
`endif
        applyStimulus(32'd100, 4'd3);
        k = 1; validAt = -1; pulses = 0; prevReset = 1'b0;
        while (k < 2000 && validAt < 0) begin
            @(negedge clk);
            if (dutReset === 1'b1 && prevReset === 1'b0) pulses++;
            prevReset = dutReset;
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (pulses != expPulses) begin
            failures++;
            $display("[TB] FAIL clear_pulses: got %0d, expected %0d", pulses, expPulses);
        end
        checks++;
        if (validAt != expValidAt) begin
            failures++;
            $display("[TB] FAIL repeat_latency: got cycle %0d, expected %0d", validAt, expValidAt);
        end
    endtask

    task automatic test_toggle();
        int k, validAt;
        toggleMode = 1'b1;
        pushExpected(36'd50, ~36'd1, 1'b1);
        applyStimulus(32'd100, 4'd0);
        k = 1; validAt = -1;
        while (k < 400 && validAt < 0) begin
            @(negedge clk);
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (validAt != 116) begin
            failures++;
            $display("[TB] FAIL retry_latency: got cycle %0d, expected 116", validAt);
        end
        toggleMode = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL error_sticky: got error=%b busy=%b, expected 1 0", error, busy);
        end
        pushExpected(36'd50, {36{1'b1}}, 1'b0);
        applyStimulus(32'd100, 4'd0);
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL error_clear_on_start: got %b, expected 0", error);
        end
        k = 1; validAt = -1;
        while (k < 400 && validAt < 0) begin
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
            @(negedge clk);
        end
        checks++;
        if (validAt < 0) begin
            failures++;
            $display("[TB] FAIL rerun_after_error: got no result within 400 cycles, expected a result");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int   k, validAt;
        logic sawValid;
        applyStimulus(32'd100, 4'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (dutEnable !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_precondition: got enable=%b busy=%b, expected 1 1", dutEnable, busy);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dutEnable !== 1'b0 || resultValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_to_idle: got busy=%b enable=%b valid=%b, expected 0 0 0", busy, dutEnable, resultValid);
        end
        sawValid = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (resultValid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_result: got valid asserted, expected never");
        end
        pushExpected(36'd50, {36{1'b1}}, 1'b0);
        applyStimulus(32'd100, 4'd0);
        k = 1; validAt = -1;
        while (k < 400 && validAt < 0) begin
            @(negedge clk);
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (validAt != 110) begin
            failures++;
            $display("[TB] FAIL run_after_abort: got valid at cycle %0d, expected 110", validAt);
        end
    endtask

    task automatic test_reset_mid_run();
        applyStimulus(32'd100, 4'd0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        resetB = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dutReset !== 1'b1 || {busy, dutEnable, dutLoad, resultValid, error} !== 5'b0 ||
            resultCount !== 36'd0 || dutIntegrationTime !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_run: got reset=%b flags=%b count=%0d itime=%0d, expected 1 00000 0 0",
                     dutReset, {busy, dutEnable, dutLoad, resultValid, error}, resultCount, dutIntegrationTime);
        end
        @(posedge clk); #1;
        resetB = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_ready_hold();
        int   k, validAt;
        logic stable, stayedIdle;
        resultReady = 1'b0;
        pushExpected(36'd50, {36{1'b1}}, 1'b0);
        applyStimulus(32'd100, 4'd0);
        k = 1; validAt = -1;
        while (k < 400 && validAt < 0) begin
            @(negedge clk);
            if (resultValid === 1'b1) validAt = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (validAt != 110) begin
            failures++;
            $display("[TB] FAIL hold_latency: got cycle %0d, expected 110", validAt);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            if (resultValid !== 1'b1 || resultCount !== 36'd50 || busy !== 1'b1) stable = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_stable: got valid=%b count=%0d, expected 1 and 50 throughout", resultValid, resultCount);
        end
        resultReady = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        stayedIdle = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || dutReset !== 1'b0 || resultValid !== 1'b0) stayedIdle = 1'b0;
        end
        checks++;
        if (stayedIdle !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_ignored_when_busy: got busy=%b reset=%b, expected idle", busy, dutReset);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_time();
        test_repeats();
        test_toggle();
        test_abort();
        test_reset_mid_run();
        test_ready_hold();
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_measure_sequencer.md
# adder_measure_sequencer

Sequencer for one instrumented-adder measurement run: clears the adder's counters, loads and enables its integration counter, waits for `done`, lets the ring counter settle, then captures it with a double-sample check. Optionally repeats and accumulates runs. Sits between the configuration/readout logic and the instrumented adder: drives the adder's counter-control pins and consumes its `done` and ring-counter outputs.

## Interface

**Parameters**
- `COUNT_BITS`, default 32: width of the ring-counter input and of the integration time.
- `REP_BITS`, default 4: width of the repeat-count input.
- `SETTLE_CYCLES`, default 4: wait in `clk` cycles after `done` before the first sample. Must be ≥ 1.
- `MAX_RETRIES`, default 3: number of failed double-sample compares allowed before `error`.

**Ports** (one clock; reset is synchronous and active-low)
- `clk`, in, 1: system clock; also the adder's `clk`.
- `reset_b`, in, 1: synchronous active-low reset.
- `start`, in, 1: single-cycle start request, accepted only in IDLE.
- `abort`, in, 1: returns the block to IDLE from any state.
- `integration_time`, in, COUNT_BITS: clk cycles per run.
- `repeats`, in, REP_BITS: number of runs is `repeats`+1. Latched at `start`.
- `dut_reset`, out, 1: active-high reset to the adder's counters.
- `dut_counter_load`, out, 1: drives the adder's `counter_load`.
- `dut_counter_enable`, out, 1: drives the adder's `counter_enable`.
- `dut_integration_time`, out, COUNT_BITS: latched copy of `integration_time`.
- `dut_done`, in, 1: the adder's `done`.
- `dut_ring_count`, in, COUNT_BITS: the adder's ring-counter output. This is asynchronous to `clk`.
- `busy`, out, 1: high in every state except IDLE.
- `result_valid`, out, 1; `result_ready`, in, 1: result handshake.
- `result_count`, out, COUNT_BITS+REP_BITS: captured or accumulated count.
- `error`, out, 1: sticky; cleared by the next accepted `start`.

## Operation

States: IDLE → CLEAR → LOAD → ARM → RUN → SETTLE → SAMPLE → (CLEAR, or RESULT) → IDLE.

- **IDLE.** `start` latches `integration_time`, `repeats`, and run index 0; clears the accumulator and `error`; goes to CLEAR.
- **CLEAR** (1 cycle). `dut_reset`=1.
- **LOAD** (1 cycle). `dut_counter_load`=1.
- **ARM** (1 cycle). `dut_counter_enable`=1. `dut_done` is ignored here because the loaded value is not yet visible.
- **RUN.** `dut_counter_enable`=1 until `dut_done`=1, then go to SETTLE. `dut_counter_enable` stays high through SETTLE and SAMPLE, so the ring counter is gated only by the adder's own zero detect.
- **SETTLE.** Counts SETTLE_CYCLES.
- **SAMPLE.** Registers `dut_ring_count` on two consecutive cycles.
  - Samples equal: add the sample (zero-extended) to the accumulator.
  - Samples differ: increment the retry count and resample. When retries exceed MAX_RETRIES, set `error` and capture the last sample anyway.
  - After a capture: if run index < latched `repeats`, increment the run index and go to CLEAR; otherwise go to RESULT.
- **RESULT.** `result_valid`=1 and `result_count` is held stable until `result_ready`. Transfer happens on a cycle with `valid & ready`; return to IDLE the next cycle.

Boundary conditions:
- `integration_time`=0: `dut_done` is already high in ARM+1. The run completes with the adder's count of 0 (`force_count` is not driven by this block).
- `repeats`=max: accumulator width COUNT_BITS+REP_BITS guarantees no overflow.
- `abort` (priority over `start`, below reset): next state IDLE, `result_valid` drops, accumulator is kept but not presented.
- `start` while busy: ignored.
- `reset_b` low mid-run: every output is forced to its reset value on the next edge. The adder is not cleared until the next CLEAR.

## Timing

- Reset values: all outputs 0 except `dut_reset`=1, so the adder is held cleared.
- Every output is registered, with no combinational path from input to output.
- Latency for a single run with no retries: `start` at cycle 0 → CLEAR at 1, LOAD at 2, ARM at 3, RUN from 4. If `dut_done` rises at cycle D, SETTLE runs D+1..D+SETTLE_CYCLES, SAMPLE takes 2 cycles, and `result_valid` is asserted at D+SETTLE_CYCLES+3.
- Each extra repeat adds that full sequence again from CLEAR.
- `dut_done` and `dut_ring_count` are sampled only on `clk`. The double-sample compare is the only crossing mechanism for the ring count.

## Configuration

- `ADDER_MEASURE_ACCUM_EN`
  - Defined: repeats and accumulation are enabled as described above.
  - Undefined: `repeats` is ignored (treated as 0). `result_count` is the single captured sample, zero-extended. The accumulator adder is removed.

## Structure

- Shared package `adder_measure_pkg`:
  - State enum (IDLE, CLEAR, LOAD, ARM, RUN, SETTLE, SAMPLE, RESULT).
  - Default constants for SETTLE_CYCLES and MAX_RETRIES.
- One natural sub-module: `stable_sampler`. It takes the asynchronous bus, performs the two-cycle sample and compare, and reports `match`, `sample`, and the retry count. It is reusable for other ring-counter readouts.

## Test plan

- Behavioural adder model, `integration_time`=100, `repeats`=0, ring counting 1 per 2 clk: `result_count`=50, `error`=0, `result_valid` at D+7 with SETTLE_CYCLES=4.
- `ADDER_MEASURE_ACCUM_EN` defined, `repeats`=3, each run returning 50: `result_count`=200, with 4 CLEAR pulses observed.
- `integration_time`=0: completes with `result_count`=0 and no hang in RUN.
- `dut_ring_count` toggling every cycle after `done`: `error`=1 after 4 failed compares; result still delivered; `error` cleared by the next `start`.
- `abort` during RUN: IDLE the next cycle, `busy`=0, `result_valid` never asserted. A subsequent `start` measures normally.
- `result_ready` held low for 10 cycles: `result_valid` and `result_count` stay stable; a `start` pulse during that window is ignored.
